// File: rtl/uart_receiver_pkg.sv
// Shared types and defaults for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_receiver_pkg;

  // Receive FSM encoding; values are fixed so they read the same in waveforms everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int UART_DEFAULT_OVERSAMPLE = 16;
  localparam int UART_DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/uart_receiver_if.sv
// Control, serial input and byte/flag handshake between the UART receiver and its host port logic.
// Latency: n/a (wires only).
// Backpressure: none; the host acknowledges a byte with a one-cycle rd strobe.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic                 baud_tick;
  logic                 rx;
  logic                 rd;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  // Host / baud generator / line side.
  modport master (
    output enable, baud_tick, rx, rd,
    input  data_out, data_ready, framing_error, overrun_error, busy
  );

  // Receiver side.
  modport slave (
    input  enable, baud_tick, rx, rd,
    output data_out, data_ready, framing_error, overrun_error, busy
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Latency: 2 clk from d to q.
// Backpressure: none.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both reset to the line's idle level so no false edge appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receiver (N data bits, no parity, 1 stop) sampling each bit at mid-bit.
// Latency: data_ready rises 1 clk after the baud_tick that samples the middle of the stop bit.
// Backpressure: none; an unread byte is overwritten by the next one and overrun_error is raised.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  // Half a bit after the start edge lands mid start bit; a full bit after that lands mid data bit.
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_ready_q, data_ready_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_error_q, overrun_error_d;

  uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Frame FSM, oversample counters and output flags; a completing byte overrides a same-cycle rd.
  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    data_ready_d    = data_ready_q;
    framing_error_d = framing_error_q;
    overrun_error_d = overrun_error_q;

    if (bus.rd && data_ready_q) begin
      data_ready_d    = 1'b0;
      overrun_error_d = 1'b0;
    end

    if (!bus.enable) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == START_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // Line back high at mid start bit: treat as a glitch and drop it silently.
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BITS_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d      = '0;
            // Leave at mid stop bit so a start edge half a bit later is still caught.
            state_d         = IDLE;
            data_out_d      = shift_q;
            data_ready_d    = 1'b1;
            framing_error_d = ~rx_s;
            if (data_ready_q && !bus.rd) begin
              overrun_error_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun_error = overrun_error_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and random 8N1 frames against a sample-point model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_receiver;

  localparam int OS   = 16;
  localparam int CPT  = 4;          // clk per baud_tick
  localparam int CPB  = OS * CPT;   // clk per bit
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_receiver_if #(.DATA_BITS(8)) u_if ();

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Values to apply after the next clock edge.
  logic rx_val  = 1'b1;
  logic rd_val  = 1'b0;
  logic en_val  = 1'b1;
  logic rst_val = 1'b1;

  // Behavioural model: the line as the receiver sees it (2 edges late), frames as absolute sample edges.
  logic       h1 = 1'b1, h2 = 1'b1;
  bit         m_busy = 1'b0;
  int         m_start = 0;
  logic [7:0] m_shift = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ready = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;
  bit         chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    h1 = 1'b1; h2 = 1'b1;
    m_busy = 1'b0;
    m_shift = 8'h00;
    exp_data = 8'h00; exp_ready = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
  endfunction

  // Apply one clock edge to the model, using the inputs present at that edge.
  function automatic void model_edge();
    logic seen;
    logic ready_old;
    int   d;
    seen = h2;
    h2 = h1;
    h1 = u_if.rx;
    ready_old = exp_ready;
    if (u_if.rd && exp_ready) begin
      exp_ready = 1'b0;
      exp_ov = 1'b0;
    end
    if (!u_if.enable) begin
      m_busy = 1'b0;
    end else if (u_if.baud_tick) begin
      if (!m_busy) begin
        if (!seen) begin
          m_busy = 1'b1;
          m_start = cyc;
        end
      end else begin
        d = cyc - m_start;
        if (d == HALF) begin
          if (seen) m_busy = 1'b0;
        end else if (d > HALF && d <= HALF + 8 * CPB && ((d - HALF) % CPB) == 0) begin
          m_shift[(d - HALF) / CPB - 1] = seen;
        end else if (d == HALF + 9 * CPB) begin
          exp_data = m_shift;
          exp_fe = !seen;
          if (ready_old && !u_if.rd) exp_ov = 1'b1;
          exp_ready = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  endfunction

  // One clock: advance the model over the edge, then drive the next inputs.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!reset) model_edge();
    #1;
    reset          = rst_val;
    u_if.rx        = rx_val;
    u_if.rd        = rd_val;
    u_if.enable    = en_val;
    u_if.baud_tick = (((cyc + 1) % CPT) == 0);
    if (rst_val) model_reset();
  endtask

  task automatic idle(input int n);
    rx_val = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic pulse_rd();
    rd_val = 1'b1;
    cycle();
    rd_val = 1'b0;
    cycle();
  endtask

  // Drive one frame; cut aborts at that clk offset, en_off drops enable from that offset to frame end.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int cut = -1,
                            input int en_off = -1);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == cut) return;
      if (i == en_off) en_val = 1'b0;
      if (i < CPB) rx_val = 1'b0;
      else if (i < 9 * CPB) rx_val = b[i / CPB - 1];
      else rx_val = stop;
      cycle();
    end
    rx_val = 1'b1;
    en_val = 1'b1;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input logic [7:0] d, input logic r, input logic f,
                     input logic o, input logic b);
    #1;
    check(name, {u_if.data_out, u_if.data_ready, u_if.framing_error, u_if.overrun_error, u_if.busy},
          {d, r, f, o, b});
    check({"model_", name}, {exp_data, exp_ready, exp_fe, exp_ov, m_busy}, {d, r, f, o, b});
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cycle_outputs",
            {u_if.data_out, u_if.data_ready, u_if.framing_error, u_if.overrun_error, u_if.busy},
            {exp_data, exp_ready, exp_fe, exp_ov, m_busy});
    end
  end

  initial begin
    logic [7:0] rb;
    u_if.enable = 1'b1;
    u_if.baud_tick = 1'b0;
    u_if.rx = 1'b1;
    u_if.rd = 1'b0;

    repeat (5) cycle();
    chk_on = 1'b1;
    pin("reset_state", 8'h00, 0, 0, 0, 0);
    rst_val = 1'b0;
    idle(20);

    send_frame(8'h55, 1'b1);
    pin("frame_55", 8'h55, 1, 0, 0, 0);
    pulse_rd();
    pin("rd_55", 8'h55, 0, 0, 0, 0);

    send_frame(8'h00, 1'b1);
    pin("frame_00", 8'h00, 1, 0, 0, 0);
    pulse_rd();
    send_frame(8'hFF, 1'b1);
    pin("frame_ff", 8'hFF, 1, 0, 0, 0);
    pulse_rd();
    idle(10);
    pin("b2b_no_overrun", 8'hFF, 0, 0, 0, 0);

    rx_val = 1'b0;
    repeat (4) cycle();
    idle(100);
    pin("glitch", 8'hFF, 0, 0, 0, 0);

    send_frame(8'hA3, 1'b0);
    idle(100);
    pin("framing_a3", 8'hA3, 1, 1, 0, 0);
    pulse_rd();

    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    pin("overrun_34", 8'h34, 1, 0, 1, 0);
    pulse_rd();
    pin("overrun_rd", 8'h34, 0, 0, 0, 0);

    send_frame(8'hC5, 1'b1, 4 * CPB + HALF);
    pin("mid_frame_busy", 8'h34, 0, 0, 0, 1);
    rst_val = 1'b1;
    cycle();
    pin("reset_mid_frame", 8'h00, 0, 0, 0, 0);
    rst_val = 1'b0;
    idle(20);
    send_frame(8'h7E, 1'b1);
    pin("frame_7e", 8'h7E, 1, 0, 0, 0);
    pulse_rd();

    send_frame(8'h99, 1'b1, -1, 200);
    idle(50);
    pin("enable_drop", 8'h7E, 0, 0, 0, 0);

    rx_val = 1'b0;
    repeat (1240) cycle();
    idle(100);
    pin("break", 8'h00, 1, 1, 1, 0);
    pulse_rd();

    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 1) == 1) pulse_rd();
      idle($urandom_range(0, 40));
    end
    idle(700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
